lfsr_source: RTL
================

LFSR_SOURCE -- requirements
Module: lfsr_source

Interface
REQ-001 Parameter TAPS, default 8'h09, feedback tap mask: bit i set means state bit i enters the feedback XOR.
REQ-002 Parameter SEED, default 8'h01, reset state and lock-up recovery value.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run request; high starts and keeps generating, low stops after the pending sample is taken.
REQ-006 load  input  1  seed load strobe, honoured in IDLE only.
REQ-007 seed_in  input  8  seed value captured on an honoured load.
REQ-008 threshold  input  8  signed compare threshold for the downstream stage.
REQ-009 out_ready  input  1  downstream accepts the sample.
REQ-010 out_valid  output  1  out_data holds a valid sample.
REQ-011 out_data  output  8  current LFSR state, registered.
REQ-012 lt  output  1  combinational; $signed(out_data) < $signed(threshold).
REQ-013 count  output  16  number of accepted samples (handshakes).
REQ-014 lt_count  output  16  number of accepted samples with lt=1 (see Configuration).

Function
REQ-015 States: IDLE (out_valid=0) and RUN (out_valid=1); out_valid SHALL be a registered decode of the state.
REQ-016 IDLE->RUN at the edge where en=1 and load=0; out_valid rises the next cycle with out_data = current state; there is no extra fill latency.
REQ-017 Handshake: out_valid & out_ready sampled high at an edge; a sample SHALL be consumed exactly once.
REQ-018 On a handshake, state <= {state[6:0], ^(state & TAPS)} and count <= count+1.
REQ-019 Without a handshake, out_data and out_valid SHALL hold stable; this applies even if en falls.
REQ-020 RUN->IDLE only at a handshake edge with en=0; the LFSR still advances on that edge.
REQ-021 RUN with en=1 and a handshake: stay in RUN, back-to-back samples at 1 per cycle.
REQ-022 load=1 in IDLE: state <= seed_in, or SEED if seed_in==0 (lock-up guard); load has priority over en in the same cycle, and the state remains IDLE.
REQ-023 load=1 in RUN SHALL be ignored entirely.
REQ-024 If the next-state computation yields 8'h00, the state SHALL be loaded with SEED instead.
REQ-025 count and lt_count wrap 16'hFFFF -> 16'h0000 without a flag.
REQ-026 lt uses two's-complement compare: 8'h80 is less than 8'h01.

Reset
REQ-027 reset=1 forces immediately, independent of clk: state=IDLE, out_data=SEED, out_valid=0, count=0, lt_count=0.
REQ-028 Reset mid-RUN drops out_valid without a handshake; the pending sample is lost and not counted.
REQ-029 The first edge after reset release behaves as IDLE.

Configuration
REQ-030 Macro LFSR_LT_COUNT_EN: when defined, lt_count increments on each handshake with lt=1.
REQ-031 When LFSR_LT_COUNT_EN is not defined, lt_count is constant 16'h0000 and has no register; the port list is unchanged.

Verification
REQ-032 Reset, en=1, out_ready=1, TAPS=9 -> out_data sequence 01,03,07,0F,1E; count=5 after 5 handshakes.
REQ-033 out_ready=0 for 4 cycles in RUN, en dropped meanwhile -> out_data held at 03, out_valid=1; one handshake then gives IDLE with count +1.
REQ-034 IDLE, load=1 with seed_in=8'h80, threshold=8'h01 -> after en, out_data=80, lt=1 (signed); load seed_in=00 -> out_data=01.
REQ-035 Threshold 8'h05 over the sequence 01,03,07,0F,1E -> lt_count=2 with LFSR_LT_COUNT_EN defined; 0 without.
REQ-036 Load asserted in RUN with seed_in=55 -> ignored, and the sequence continues unchanged.
REQ-037 Reset pulsed mid-RUN between edges -> out_valid=0 at once, out_data=01, count=0; preset count=FFFF plus one handshake -> 0000.

Source files
------------

// File: rtl/lfsr_source.sv
// Handshaked 8-bit Fibonacci LFSR sample source with a signed threshold compare.
// Optional LFSR_LT_COUNT_EN adds a counter of accepted samples below threshold.
module lfsr_source #(
  parameter logic [7:0] TAPS = 8'h09,
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [7:0]  seed_in,
  input  logic [7:0]  threshold,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        lt,
  output logic [15:0] count,
  output logic [15:0] lt_count
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic          hs;
  logic [DW-1:0] lfsr_shift;
  logic [DW-1:0] lfsr_adv;
  logic [DW-1:0] seed_safe;

  assign hs         = valid_q & out_ready;
  assign lfsr_shift = {lfsr_q[DW-2:0], ^(lfsr_q & TAPS)};
  // An all-zero state would lock the LFSR forever, so it is replaced by SEED.
  assign lfsr_adv   = (lfsr_shift == '0) ? SEED : lfsr_shift;
  assign seed_safe  = (seed_in == '0) ? SEED : seed_in;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; load blocks the IDLE->RUN transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en && !load) state_d = RUN;
      RUN:  if (hs && !en)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    lfsr_d  = lfsr_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (load) lfsr_d = seed_safe;
      RUN: begin
        if (hs) begin
          lfsr_d  = lfsr_adv;
          count_d = count_q + CW'(1);
        end
      end
      default: lfsr_d = lfsr_q;
    endcase
  end

  // Datapath and valid registers; valid is a registered decode of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= SEED;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      valid_q <= (state_d == RUN);
    end
  end

  assign out_valid = valid_q;
  assign out_data  = lfsr_q;
  assign count     = count_q;
  assign lt        = $signed(lfsr_q) < $signed(threshold);

`ifdef LFSR_LT_COUNT_EN
  logic [CW-1:0] lt_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          lt_count_q <= '0;
    else if (hs && lt)  lt_count_q <= lt_count_q + CW'(1);
  end

  assign lt_count = lt_count_q;
`else
  assign lt_count = '0;
`endif

endmodule
